ucaspian_syn_sched: RTL and testbench
=====================================

Name: ucaspian_syn_sched

Overview:
- Synapse-fire scheduler between the axon stage and one synapse unit.
- Neuron-fire requesters each present a synapse range: start address plus count.
- Block arbitrates round-robin, grants one range at a time, walks it address by address and drives the synapse unit's syn_addr/syn_vld/syn_rdy fire port.
- Reports per-step idleness for time sync.

Parameters:
- NREQ, 2, number of requesters (2..8).
- ADDR_W, 10, synapse address width (1024 synapses).
- CNT_W, 8, range count width; count 0..255.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  global run enable, shared with the synapse unit.
- abort  in  1  synchronous flush (clear_act/clear_config).
- req_vld  in  NREQ  per-requester range valid.
- req_rdy  out  NREQ  per-requester accept; one-hot or zero.
- req_start  in  NREQ*ADDR_W  packed start addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_count  in  NREQ*CNT_W  packed synapse counts.
- syn_addr  out  ADDR_W  synapse address to the synapse unit.
- syn_vld  out  1  fire valid.
- syn_rdy  in  1  synapse unit ready.
- busy  out  1  range in progress.
- step_done  out  1  registered; scheduler idle, no pending requests.

Behaviour:
- Reset (reset_n low, async):
  - state=IDLE, syn_vld=0, syn_addr=0, busy=0, step_done=0.
  - rr_ptr=0, remaining=0.
  - req_rdy is combinational and therefore 0.
- States: IDLE, ISSUE.
- IDLE, arbitration:
  - When enable=1 and any req_vld is high, pick the first requester at or after rr_ptr, searching upward mod NREQ.
  - req_rdy[winner]=1 combinationally, same cycle. All other req_rdy=0.
  - In ISSUE, when enable=0, or when abort=1: req_rdy=0.
- IDLE, accept (req_vld & req_rdy):
  - Latch cur=req_start and remaining=req_count.
  - rr_ptr <= winner+1 mod NREQ.
  - count==0: range is consumed and dropped, stay IDLE, no fire issued.
  - count>0: go to ISSUE next cycle with syn_vld=1, syn_addr=start.
- ISSUE:
  - syn_vld=1, busy=1.
  - A transfer is counted only when enable & syn_vld & syn_rdy.
  - On each transfer: cur <= cur+1, wrapping 1023->0 (mod 2^ADDR_W); remaining <= remaining-1.
  - Transfer with remaining==1: next cycle state=IDLE, syn_vld=0.
  - Minimum per-range latency: accept cycle + count issue cycles.
  - Back-to-back ranges have one IDLE cycle between them.
- Handshake rules:
  - Once syn_vld=1, syn_vld and syn_addr stay stable until the transfer completes, regardless of enable or syn_rdy.
  - syn_vld never drops without a transfer, except on abort or reset.
- Throughput: one fire per cycle when syn_rdy stays high.
- enable low:
  - No accepts.
  - ISSUE holds its outputs frozen.
  - Counters and state are unchanged.
- abort (synchronous, highest priority over everything except reset):
  - Next cycle: state=IDLE, syn_vld=0, busy=0, remaining=0, rr_ptr=0.
  - Any range in progress is discarded.
  - No req_rdy during the abort cycle.
- step_done (registered):
  - <= (state==IDLE) & ~|req_vld & ~abort.
  - Low the cycle after any request is pending or a range is in progress.
- Simultaneous events:
  - Final transfer plus new req_vld: the request is not accepted that cycle. It is accepted on the following IDLE cycle.
  - Abort plus transfer: abort wins; the transfer is not counted by this block.
- Wrap: start=1022, count=4 issues addresses 1022, 1023, 0, 1.
- Max count 255 from start 0 issues addresses 0..254.

Test Plan:
- Single range: req0 start=0x010 count=3, syn_rdy=1.
  - req_rdy[0] pulses once.
  - syn_addr 0x010, 0x011, 0x012 on 3 consecutive cycles.
  - Then syn_vld=0 and step_done=1 one cycle after returning to IDLE.
- Backpressure: count=2, syn_rdy low for 4 cycles after the first valid.
  - syn_vld and syn_addr stay stable at the start address for all 4 cycles.
  - Exactly 2 transfers occur in total.
- Round-robin: req0 and req1 held valid continuously, count=1 each, start 100 and 200.
  - Issue order is 100, 200, 100, 200.
  - rr_ptr alternates.
- Wrap and zero count:
  - start=1022 count=4 issues 1022, 1023, 0, 1.
  - count=0 from req1 is accepted (req_rdy pulse) with no syn_vld.
- Abort mid-range: count=10, abort asserted after 3 transfers.
  - Next cycle syn_vld=0, busy=0.
  - A later req0 range starts from its own start address.
  - rr_ptr is back at 0.
- Async reset mid-ISSUE, with no clock edge:
  - syn_vld=0 immediately.
  - After release, the first accept goes to req0.

Source files
------------

// File: rtl/ucaspian_syn_sched.sv
// rtl/ucaspian_syn_sched.sv - round-robin synapse-fire scheduler between the axon stage and one synapse unit
module ucaspian_syn_sched #(
   parameter int NREQ   = 2,
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic                   abort,
   input  logic [NREQ-1:0]        req_vld,
   output logic [NREQ-1:0]        req_rdy,
   input  logic [NREQ*ADDR_W-1:0] req_start,
   input  logic [NREQ*CNT_W-1:0]  req_count,
   output logic [ADDR_W-1:0]      syn_addr,
   output logic                   syn_vld,
   input  logic                   syn_rdy,
   output logic                   busy,
   output logic                   step_done
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t             state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   winner;
   logic [PTR_W-1:0]   next_ptr;
   logic [PTR_W-1:0]   idx_p;
   logic               found;
   logic [CNT_W-1:0]   remaining;
   logic [ADDR_W-1:0]  win_start;
   logic [CNT_W-1:0]   win_count;
   logic               accept;
   logic               xfer;
   int                 idx;

   // First valid requester at or after rr_ptr, searching upward modulo NREQ.
   always_comb begin
      found  = 1'b0;
      winner = rr_ptr;
      idx    = 0;
      idx_p  = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         idx_p = PTR_W'(idx);
         if (!found && req_vld[idx_p]) begin
            found  = 1'b1;
            winner = idx_p;
         end
      end
   end

   assign next_ptr  = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + 1'b1;
   assign win_start = req_start[winner*ADDR_W +: ADDR_W];
   assign win_count = req_count[winner*CNT_W +: CNT_W];
   assign accept    = (state == IDLE) && enable && !abort && found;
   assign xfer      = (state == ISSUE) && enable && syn_vld && syn_rdy;

   always_comb begin
      req_rdy = '0;
      if (accept) req_rdy[winner] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         syn_vld   <= 1'b0;
         syn_addr  <= '0;
         busy      <= 1'b0;
         step_done <= 1'b0;
         rr_ptr    <= '0;
         remaining <= '0;
      end else begin
         step_done <= (state == IDLE) && !(|req_vld) && !abort;
         if (abort) begin
            state     <= IDLE;
            syn_vld   <= 1'b0;
            busy      <= 1'b0;
            remaining <= '0;
            rr_ptr    <= '0;
         end else if (accept) begin
            rr_ptr    <= next_ptr;
            syn_addr  <= win_start;
            remaining <= win_count;
            // A zero-count range is consumed here without ever firing.
            if (win_count != '0) begin
               state   <= ISSUE;
               syn_vld <= 1'b1;
               busy    <= 1'b1;
            end
         end else if (xfer) begin
            syn_addr  <= syn_addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
               state   <= IDLE;
               syn_vld <= 1'b0;
               busy    <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ucaspian_syn_sched.sv
// tb/tb_ucaspian_syn_sched.sv - directed vector table plus randomized run against a range-queue model
module tb_ucaspian_syn_sched;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic        abort = 1'b0;
   logic [1:0]  req_vld = '0;
   logic [1:0]  req_rdy;
   logic [19:0] req_start = '0;
   logic [15:0] req_count = '0;
   logic [9:0]  syn_addr;
   logic        syn_vld;
   logic        syn_rdy = 1'b0;
   logic        busy;
   logic        step_done;

   ucaspian_syn_sched #(.NREQ(2), .ADDR_W(10), .CNT_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .abort(abort),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_start(req_start), .req_count(req_count),
      .syn_addr(syn_addr), .syn_vld(syn_vld), .syn_rdy(syn_rdy),
      .busy(busy), .step_done(step_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       en;
      logic       ab;
      logic [1:0] vld;
      logic       rdy;
      logic [9:0] s0;
      logic [7:0] c0;
      logic [9:0] s1;
      logic [7:0] c1;
      logic [1:0] e_rdy;
      logic       e_vld;
      logic [9:0] e_addr;
      logic       e_done;
   } vec_t;

   vec_t tbl[$];
   int   tests = 0;
   int   fails = 0;

   // Model: the addresses still owed to the synapse unit, in issue order.
   int   q[$];
   int   mptr = 0;
   logic mdone = 1'b0;

   function automatic void check(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endfunction

   function automatic void row(int en, int ab, int vld, int rdy, int s0, int c0, int s1, int c1,
                               int e_rdy, int e_vld, int e_addr, int e_done);
      vec_t v;
      v.en = 1'(en);   v.ab = 1'(ab);   v.vld = 2'(vld); v.rdy = 1'(rdy);
      v.s0 = 10'(s0);  v.c0 = 8'(c0);   v.s1 = 10'(s1);  v.c1 = 8'(c1);
      v.e_rdy = 2'(e_rdy); v.e_vld = 1'(e_vld); v.e_addr = 10'(e_addr); v.e_done = 1'(e_done);
      tbl.push_back(v);
   endfunction

   function automatic int pick();
      for (int k = 0; k < 2; k++) begin
         if (req_vld[(mptr + k) % 2]) return (mptr + k) % 2;
      end
      return -1;
   endfunction

   task automatic drive(input logic en, input logic ab, input logic [1:0] vld, input logic rdy,
                        input logic [9:0] s0, input logic [7:0] c0,
                        input logic [9:0] s1, input logic [7:0] c1);
      int w;
      @(negedge clk);
      enable = en; abort = ab; req_vld = vld; syn_rdy = rdy;
      req_start = {s1, s0}; req_count = {c1, c0};
      #1;
      w = (q.size() == 0 && enable && !abort) ? pick() : -1;
      check("req_rdy", int'(req_rdy), (w < 0) ? 0 : (1 << w));
      check("syn_vld", int'(syn_vld), int'(q.size() != 0));
      check("busy", int'(busy), int'(q.size() != 0));
      if (q.size() != 0) check("syn_addr", int'(syn_addr), q[0]);
      check("step_done", int'(step_done), int'(mdone));
   endtask

   task automatic tick();
      int w, st, cn;
      @(posedge clk);
      mdone = (q.size() == 0) && !(|req_vld) && !abort;
      if (abort) begin
         q.delete();
         mptr = 0;
      end else if (enable) begin
         if (q.size() == 0) begin
            w = pick();
            if (w >= 0) begin
               mptr = (w + 1) % 2;
               st = int'(req_start[w*10 +: 10]);
               cn = int'(req_count[w*8 +: 8]);
               for (int i = 0; i < cn; i++) q.push_back((st + i) % 1024);
            end
         end else if (syn_rdy) begin
            void'(q.pop_front());
         end
      end
   endtask

   task automatic model_reset();
      q.delete();
      mptr = 0;
      mdone = 1'b0;
   endtask

   initial begin
      // Single range, backpressure, round-robin, wrap, zero count, abort.
      row(1,0,1,0,'h10,3,0,0,     1,0,0,1);
      row(1,0,0,1,0,0,0,0,        0,1,'h10,0);
      row(1,0,0,1,0,0,0,0,        0,1,'h11,0);
      row(1,0,0,1,0,0,0,0,        0,1,'h12,0);
      row(1,0,0,1,0,0,0,0,        0,0,0,0);
      row(1,0,0,1,0,0,0,0,        0,0,0,1);
      row(1,0,2,0,0,0,'h20,2,     2,0,0,1);
      for (int i = 0; i < 4; i++) row(1,0,0,0,0,0,0,0, 0,1,'h20,0);
      row(1,0,0,1,0,0,0,0,        0,1,'h20,0);
      row(1,0,0,1,0,0,0,0,        0,1,'h21,0);
      row(1,0,0,1,0,0,0,0,        0,0,0,0);
      row(1,0,3,1,100,1,200,1,    1,0,0,1);
      row(1,0,3,1,100,1,200,1,    0,1,100,0);
      row(1,0,3,1,100,1,200,1,    2,0,0,0);
      row(1,0,3,1,100,1,200,1,    0,1,200,0);
      row(1,0,3,1,100,1,200,1,    1,0,0,0);
      row(1,0,3,1,100,1,200,1,    0,1,100,0);
      row(1,0,3,1,100,1,200,1,    2,0,0,0);
      row(1,0,0,1,0,0,0,0,        0,1,200,0);
      row(1,0,1,1,1022,4,0,0,     1,0,0,0);
      row(1,0,0,1,0,0,0,0,        0,1,1022,0);
      row(1,0,0,1,0,0,0,0,        0,1,1023,0);
      row(1,0,0,1,0,0,0,0,        0,1,0,0);
      row(1,0,0,1,0,0,0,0,        0,1,1,0);
      row(1,0,2,1,0,0,5,0,        2,0,0,0);
      row(1,0,0,1,0,0,0,0,        0,0,0,0);
      row(1,0,0,1,0,0,0,0,        0,0,0,1);
      row(1,0,1,1,300,10,0,0,     1,0,0,1);
      row(1,0,0,1,0,0,0,0,        0,1,300,0);
      row(1,0,0,1,0,0,0,0,        0,1,301,0);
      row(1,0,0,1,0,0,0,0,        0,1,302,0);
      row(1,1,3,1,400,1,500,1,    0,1,303,0);
      row(1,0,0,1,0,0,0,0,        0,0,0,0);
      row(1,0,3,1,400,1,500,1,    1,0,0,1);
      row(1,0,0,1,0,0,0,0,        0,1,400,0);
      row(1,0,0,1,0,0,0,0,        0,0,0,0);

      model_reset();
      #1;
      check("rst_syn_vld", int'(syn_vld), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_syn_addr", int'(syn_addr), 0);
      check("rst_step_done", int'(step_done), 0);
      check("rst_req_rdy", int'(req_rdy), 0);
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1; enable = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 0, 0, 0, 0, 0);
         tick();
      end

      foreach (tbl[i]) begin
         drive(tbl[i].en, tbl[i].ab, tbl[i].vld, tbl[i].rdy,
               tbl[i].s0, tbl[i].c0, tbl[i].s1, tbl[i].c1);
         check($sformatf("tbl%0d_req_rdy", i), int'(req_rdy), int'(tbl[i].e_rdy));
         check($sformatf("tbl%0d_syn_vld", i), int'(syn_vld), int'(tbl[i].e_vld));
         check($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].e_vld));
         if (tbl[i].e_vld) check($sformatf("tbl%0d_syn_addr", i), int'(syn_addr), int'(tbl[i].e_addr));
         check($sformatf("tbl%0d_step_done", i), int'(step_done), int'(tbl[i].e_done));
         tick();
      end

      // Asynchronous reset in the middle of a range, between clock edges.
      drive(1, 0, 1, 1, 50, 5, 0, 0); tick();
      drive(1, 0, 0, 1, 0, 0, 0, 0);  tick();
      drive(1, 0, 0, 1, 0, 0, 0, 0);  tick();
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("async_syn_vld", int'(syn_vld), 0);
      check("async_busy", int'(busy), 0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1; req_vld = '0;
      tick();
      drive(1, 0, 3, 1, 600, 1, 700, 1);
      check("post_reset_winner", int'(req_rdy), 1);
      tick();

      // Randomized traffic: stalls, enable gaps, aborts, wraps, long ranges.
      for (int n = 0; n < 1500; n++) begin
         logic [9:0] s0, s1;
         logic [7:0] c0, c1;
         s0 = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1018, 1023)) : 10'($urandom_range(0, 1023));
         s1 = 10'($urandom_range(0, 1023));
         c0 = ($urandom_range(0, 59) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
         c1 = 8'($urandom_range(0, 6));
         drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 49) == 0),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), s0, c0, s1, c1);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
